// File: rtl/mixer_pkg.sv
// Shared types and sizing helpers for multichannel_mixer and its pan controller.
package mixer_pkg;

  typedef enum logic [1:0] {
    PAN_CENTER = 2'b00,
    PAN_LEFT   = 2'b01,
    PAN_RIGHT  = 2'b10,
    PAN_MUTE   = 2'b11
  } pan_e;

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } state_e;

  localparam int DEFAULT_GAIN_W = 4;

  function automatic int unity_gain(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  localparam int DEFAULT_UNITY_GAIN = unity_gain(DEFAULT_GAIN_W);

  // Wide enough that NUM_CH products at maximum gain cannot overflow.
  function automatic int acc_width(input int sample_w, input int gain_w, input int num_ch);
    return sample_w + gain_w + $clog2(num_ch);
  endfunction

  function automatic logic feeds_left(input pan_e p);
    return (p == PAN_CENTER) || (p == PAN_LEFT);
  endfunction

  function automatic logic feeds_right(input pan_e p);
    return (p == PAN_CENTER) || (p == PAN_RIGHT);
  endfunction

endpackage

// File: rtl/mixer_if.sv
// Sample-side bus of multichannel_mixer: input sample set, gains and mixed stereo result.
interface mixer_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 4
);
  logic [NUM_CH*SAMPLE_W-1:0] sample_in;
  logic                       sample_valid;
  logic [NUM_CH*GAIN_W-1:0]   gain_in;
  logic signed [SAMPLE_W-1:0] sample_left;
  logic signed [SAMPLE_W-1:0] sample_right;
  logic                       out_valid;
  logic                       busy;

  modport master (
    output sample_in, sample_valid, gain_in,
    input  sample_left, sample_right, out_valid, busy
  );

  modport slave (
    input  sample_in, sample_valid, gain_in,
    output sample_left, sample_right, out_valid, busy
  );
endinterface

// File: rtl/mixer_pan_ctrl.sv
// Selected-channel counter and per-channel pan register file driven by debounced buttons.
module mixer_pan_ctrl
  import mixer_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pan_select,
  input  logic                      pan_step,
  output logic [$clog2(NUM_CH)-1:0] sel_ch,
  output logic [2*NUM_CH-1:0]       pan_state
);
  localparam int IDX_W = $clog2(NUM_CH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_ch    <= '0;
      // NOTE: this register file is small and must power up CENTER, so it is reset like plain state.
      pan_state <= '0;
    end else begin
      // Step uses the pre-increment sel_ch when both buttons fire together.
      if (pan_step)
        pan_state[sel_ch*2 +: 2] <= pan_state[sel_ch*2 +: 2] + 2'd1;
      if (pan_select)
        sel_ch <= (sel_ch == IDX_W'(NUM_CH - 1)) ? '0 : sel_ch + 1'b1;
    end
  end

endmodule

// File: rtl/multichannel_mixer.sv
// NUM_CH-channel gain/pan mixer with one time-multiplexed MAC and saturating stereo output.
// Optional clip_count output is enabled by defining MIXER_CLIP_COUNT_EN.
module multichannel_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  mixer_if.slave                    bus,
  input  logic                      pan_select,
  input  logic                      pan_step,
  output logic [$clog2(NUM_CH)-1:0] sel_ch,
  output logic [2*NUM_CH-1:0]       pan_state
`ifdef MIXER_CLIP_COUNT_EN
  ,
  output logic [15:0]               clip_count
`endif
);
  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int ACC_W  = acc_width(SAMPLE_W, GAIN_W, NUM_CH);
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  state_e                     state_q, state_d;
  logic                       accept, last_ch;
  logic [IDX_W-1:0]           idx_q;
  logic [NUM_CH*SAMPLE_W-1:0] samp_q;
  logic [NUM_CH*GAIN_W-1:0]   gain_q;
  logic [2*NUM_CH-1:0]        pan_q;
  logic signed [SAMPLE_W-1:0] samp_k;
  logic [GAIN_W-1:0]          gain_k;
  pan_e                       pan_k;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    p_ext, acc_l_q, acc_r_q, acc_l_d, acc_r_d;
  logic signed [SAMPLE_W-1:0] sat_l, sat_r;
  logic                       clip_l, clip_r;

  mixer_pan_ctrl #(.NUM_CH(NUM_CH)) u_pan_ctrl (
    .clk        (clk),
    .reset_n    (reset_n),
    .pan_select (pan_select),
    .pan_step   (pan_step),
    .sel_ch     (sel_ch),
    .pan_state  (pan_state)
  );

  assign last_ch  = (idx_q == IDX_W'(NUM_CH - 1));
  assign bus.busy = (state_q == ST_ACCUM);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.sample_valid) begin
          state_d = ST_ACCUM;
          accept  = 1'b1;
        end
      end
      ST_ACCUM: if (last_ch) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // MAC for channel idx_q; gain is unsigned, so it is zero-extended before the signed multiply.
  assign samp_k  = samp_q[idx_q*SAMPLE_W +: SAMPLE_W];
  assign gain_k  = gain_q[idx_q*GAIN_W +: GAIN_W];
  assign pan_k   = pan_e'(pan_q[idx_q*2 +: 2]);
  assign prod    = samp_k * $signed({1'b0, gain_k});
  assign p_ext   = ACC_W'(prod >>> (GAIN_W - 1));
  assign acc_l_d = acc_l_q + (feeds_left(pan_k)  ? p_ext : {ACC_W{1'b0}});
  assign acc_r_d = acc_r_q + (feeds_right(pan_k) ? p_ext : {ACC_W{1'b0}});

  assign clip_l = (acc_l_d > OUT_MAX) || (acc_l_d < OUT_MIN);
  assign clip_r = (acc_r_d > OUT_MAX) || (acc_r_d < OUT_MIN);
  assign sat_l  = (acc_l_d > OUT_MAX) ? OUT_MAX[SAMPLE_W-1:0] :
                  (acc_l_d < OUT_MIN) ? OUT_MIN[SAMPLE_W-1:0] : acc_l_d[SAMPLE_W-1:0];
  assign sat_r  = (acc_r_d > OUT_MAX) ? OUT_MAX[SAMPLE_W-1:0] :
                  (acc_r_d < OUT_MIN) ? OUT_MIN[SAMPLE_W-1:0] : acc_r_d[SAMPLE_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      samp_q           <= '0;
      gain_q           <= '0;
      pan_q            <= '0;
      acc_l_q          <= '0;
      acc_r_q          <= '0;
      bus.sample_left  <= '0;
      bus.sample_right <= '0;
      bus.out_valid    <= 1'b0;
`ifdef MIXER_CLIP_COUNT_EN
      clip_count       <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register here updates from the pre-edge values.
      state_q       <= state_d;
      bus.out_valid <= 1'b0;
      if (accept) begin
        samp_q  <= bus.sample_in;
        gain_q  <= bus.gain_in;
        pan_q   <= pan_state;
        acc_l_q <= '0;
        acc_r_q <= '0;
        idx_q   <= '0;
      end else if (state_q == ST_ACCUM) begin
        acc_l_q <= acc_l_d;
        acc_r_q <= acc_r_d;
        idx_q   <= idx_q + 1'b1;
        if (last_ch) begin
          bus.sample_left  <= sat_l;
          bus.sample_right <= sat_r;
          bus.out_valid    <= 1'b1;
`ifdef MIXER_CLIP_COUNT_EN
          if ((clip_l || clip_r) && (clip_count != 16'hFFFF))
            clip_count <= clip_count + 16'd1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_multichannel_mixer.sv
// Self-checking bench for multichannel_mixer: vector table, corner sequences, randomized mixes.
module tb_multichannel_mixer;
  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 4;
  localparam int IDX_W    = $clog2(NUM_CH);
  localparam int N_VEC    = 9;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pan_select = 1'b0;
  logic pan_step = 1'b0;
  logic [IDX_W-1:0]     sel_ch;
  logic [2*NUM_CH-1:0]  pan_state;
`ifdef MIXER_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  mixer_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W)) bus ();

  multichannel_mixer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .pan_select (pan_select),
    .pan_step   (pan_step),
    .sel_ch     (sel_ch),
    .pan_state  (pan_state)
`ifdef MIXER_CLIP_COUNT_EN
    ,
    .clip_count (clip_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int s[NUM_CH];
    int g[NUM_CH];
    int el;
    int er;
  } vec_t;

  vec_t vecs[N_VEC];
  int   n_cmp = 0;
  int   n_err = 0;
  int   vs[NUM_CH];
  int   vg[NUM_CH];
  int   pan_m[NUM_CH];
  int   sel_m = 0;
  int   clip_m = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int s0, input int s1, input int s2, input int s3,
                         input int g0, input int g1, input int g2, input int g3,
                         input int el, input int er);
    vecs[i].s[0] = s0; vecs[i].s[1] = s1; vecs[i].s[2] = s2; vecs[i].s[3] = s3;
    vecs[i].g[0] = g0; vecs[i].g[1] = g1; vecs[i].g[2] = g2; vecs[i].g[3] = g3;
    vecs[i].el = el;   vecs[i].er = er;
  endtask

  // Reference: each channel contributes floor(sample*gain / 2^(GAIN_W-1)) to the sides its pan feeds.
  function automatic void ref_mix(output int l, output int r, output bit clip);
    int lo, hi, p;
    lo = -(1 << (SAMPLE_W - 1));
    hi = (1 << (SAMPLE_W - 1)) - 1;
    l = 0;
    r = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      p = (vs[i] * vg[i]) >>> (GAIN_W - 1);
      if (pan_m[i] == 0 || pan_m[i] == 1) l += p;
      if (pan_m[i] == 0 || pan_m[i] == 2) r += p;
    end
    clip = (l > hi) || (l < lo) || (r > hi) || (r < lo);
    l = (l > hi) ? hi : (l < lo) ? lo : l;
    r = (r > hi) ? hi : (r < lo) ? lo : r;
  endfunction

  function automatic int pan_pack();
    int v = 0;
    for (int i = 0; i < NUM_CH; i++) v += pan_m[i] << (2 * i);
    return v;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NUM_CH; i++) begin
      bus.sample_in[i*SAMPLE_W +: SAMPLE_W] = vs[i][SAMPLE_W-1:0];
      bus.gain_in[i*GAIN_W +: GAIN_W]       = vg[i][GAIN_W-1:0];
    end
  endtask

  // Called at the negedge one cycle after the accepted pulse; returns at the out_valid cycle.
  task automatic wait_out(output int lat, output int busy_cycles);
    lat = 1;
    busy_cycles = 0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_mix(input string tag, input int el, input int er);
    int lat, bc, ml, mr;
    bit clip;
    ref_mix(ml, mr, clip);
    @(negedge clk);
    drive_inputs();
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    wait_out(lat, bc);
    if (clip) clip_m++;
    check({tag, "_latency"}, lat, NUM_CH + 1);
    check({tag, "_busy_cycles"}, bc, NUM_CH);
    check({tag, "_left"}, int'(bus.sample_left), el);
    check({tag, "_right"}, int'(bus.sample_right), er);
    @(negedge clk);
    check({tag, "_valid_pulse"}, int'(bus.out_valid), 0);
    check({tag, "_hold_left"}, int'(bus.sample_left), el);
  endtask

  task automatic press(input bit sel, input bit step);
    @(negedge clk);
    pan_select = sel;
    pan_step   = step;
    @(negedge clk);
    pan_select = 1'b0;
    pan_step   = 1'b0;
    if (step) pan_m[sel_m] = (pan_m[sel_m] + 1) % 4;
    if (sel)  sel_m = (sel_m + 1) % NUM_CH;
  endtask

  task automatic set_inputs(input int s0, input int g_all);
    for (int i = 0; i < NUM_CH; i++) begin
      vs[i] = 0;
      vg[i] = g_all;
    end
    vs[0] = s0;
  endtask

  initial begin
    int lat, bc, cnt, cap_l, ml, mr;
    bit clip;
    logic signed [SAMPLE_W-1:0] r16;

    bus.sample_in    = '0;
    bus.gain_in      = '0;
    bus.sample_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) pan_m[i] = 0;

    set_vec(0, 1000, 0, 0, 0,        8, 8, 8, 8,     1000,   1000);
    set_vec(1, 1000, 0, 0, 0,        4, 8, 8, 8,      500,    500);
    set_vec(2, 1000, 0, 0, 0,       15, 8, 8, 8,     1875,   1875);
    set_vec(3, 1000, -1000, 0, 0,    8, 8, 8, 8,        0,      0);
    set_vec(4, 30000, 30000, 30000, 30000, 8, 8, 8, 8, 32767, 32767);
    set_vec(5, -30000, -30000, -30000, -30000, 8, 8, 8, 8, -32768, -32768);
    set_vec(6, 1000, 0, 0, 0,        0, 8, 8, 8,        0,      0);
    set_vec(7, -1, 0, 0, 0,          1, 0, 0, 0,       -1,     -1);
    set_vec(8, 1000, 2000, -500, 7,  8, 8, 4, 15,    2763,   2763);

    repeat (3) @(negedge clk);
    check("reset_left", int'(bus.sample_left), 0);
    check("reset_right", int'(bus.sample_right), 0);
    check("reset_valid", int'(bus.out_valid), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_sel", int'(sel_ch), 0);
    check("reset_pan", int'(pan_state), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < N_VEC; v++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        vs[i] = vecs[v].s[i];
        vg[i] = vecs[v].g[i];
      end
      run_mix($sformatf("vec%0d", v), vecs[v].el, vecs[v].er);
    end
`ifdef MIXER_CLIP_COUNT_EN
    check("clip_count_table", int'(clip_count), 2);
`endif

    // Pan cycling on channel 0: LEFT, then MUTE after three steps, then back to CENTER.
    press(1'b0, 1'b1);
    check("pan_after_1_step", int'(pan_state[1:0]), 1);
    set_inputs(1000, 8);
    run_mix("pan_left", 1000, 0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("pan_after_3_steps", int'(pan_state[1:0]), 3);
    run_mix("pan_mute", 0, 0);
    press(1'b0, 1'b1);
    check("pan_wrap", int'(pan_state), 0);

    // Second pulse while busy is dropped; input changes mid-ACCUM do not disturb the sum.
    set_inputs(1000, 8);
    @(negedge clk);
    drive_inputs();
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(negedge clk);
    set_inputs(-7000, 15);
    drive_inputs();
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    cnt = 0;
    cap_l = 12345;
    for (int c = 0; c < 14; c++) begin
      if (bus.out_valid) begin
        cnt++;
        cap_l = int'(bus.sample_left);
      end
      @(negedge clk);
    end
    check("drop_busy_count", cnt, 1);
    check("drop_busy_left", cap_l, 1000);

    // Pulse in the out_valid cycle is accepted.
    set_inputs(1000, 8);
    @(negedge clk);
    drive_inputs();
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    wait_out(lat, bc);
    check("first_latency", lat, NUM_CH + 1);
    set_inputs(2000, 8);
    drive_inputs();
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    wait_out(lat, bc);
    check("coincident_latency", lat, NUM_CH + 1);
    check("coincident_left", int'(bus.sample_left), 2000);

    // Simultaneous select+step at sel_ch = NUM_CH-1.
    for (int i = 0; i < NUM_CH - 1; i++) press(1'b1, 1'b0);
    check("sel_before_both", int'(sel_ch), NUM_CH - 1);
    press(1'b1, 1'b1);
    check("both_pan", int'(pan_state), 1 << (2 * (NUM_CH - 1)));
    check("both_sel", int'(sel_ch), 0);

    // Reset in the middle of an accumulation.
    set_inputs(3000, 8);
    @(negedge clk);
    drive_inputs();
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_left", int'(bus.sample_left), 0);
    check("midreset_right", int'(bus.sample_right), 0);
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_pan", int'(pan_state), 0);
    check("midreset_sel", int'(sel_ch), 0);
`ifdef MIXER_CLIP_COUNT_EN
    check("midreset_clip", int'(clip_count), 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < NUM_CH; i++) pan_m[i] = 0;
    sel_m  = 0;
    clip_m = 0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid) cnt++;
      @(negedge clk);
    end
    check("midreset_no_valid", cnt, 0);

    // Randomized mixes with random button activity between them.
    for (int it = 0; it < 40; it++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--)
        press(1'($urandom), 1'($urandom));
      check($sformatf("rnd%0d_pan", it), int'(pan_state), pan_pack());
      check($sformatf("rnd%0d_sel", it), int'(sel_ch), sel_m);
      for (int i = 0; i < NUM_CH; i++) begin
        r16 = SAMPLE_W'($urandom);
        if (it % 4 == 0) r16 = (it % 8 == 0) ? 16'sd31000 : -16'sd31000;
        vs[i] = int'(r16);
        vg[i] = $urandom_range(0, (1 << GAIN_W) - 1);
      end
      ref_mix(ml, mr, clip);
      run_mix($sformatf("rnd%0d", it), ml, mr);
    end
`ifdef MIXER_CLIP_COUNT_EN
    check("clip_count_final", int'(clip_count), clip_m);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
